// File: rtl/vga_fb_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared definitions for the frame-buffer arbiter slice.
//   ROWS/COLS     : frame-buffer geometry (96 x 128)
//   DATA_W        : pixel width, 4:4:4 RGB
//   ROW_W/COL_W   : row/column index widths
//   fb_state_t    : arbiter FSM state encoding
//   fb_addr()     : BRAM address from {row, col}
// -----------------------------------------------------------------------------
package vga_fb_pkg;

   localparam int ROWS   = 96;
   localparam int COLS   = 128;
   localparam int DATA_W = 12;
   localparam int ROW_W  = 7;
   localparam int COL_W  = $clog2(COLS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } fb_state_t;

   // Row-major addressing: a full power-of-two column field per row keeps
   // the address a plain concatenation (no multiplier).
   function automatic logic [ROW_W+COL_W-1:0] fb_addr(
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col
   );
      return {row, col};
   endfunction

endpackage

// File: rtl/vga_fb_wr_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_wr_fifo
// Synchronous FIFO holding pending pixel writes ({addr, data} entries).
//   clk, reset   : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry (caller guarantees !full)
//   pop          : discard head entry (caller guarantees !empty)
//   head_data    : current head entry, combinational from the storage array
//   full, empty  : occupancy flags
// Pointers carry one extra wrap bit so full/empty need no separate counter.
// -----------------------------------------------------------------------------
module vga_fb_wr_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;

   // Storage is not reset: resetting the pointers is enough to discard it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
         end
      end
   end

   assign head_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

endmodule

// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Schedules the single-port frame-buffer BRAM between display scan-out reads
// (absolute priority) and buffered pixel writes (issued in idle cycles,
// optionally only during vertical blanking).
//   clk, reset          : clock, asynchronous active-high reset
//   disp_req/row/col    : display read request, sampled every cycle
//   disp_data/valid     : read pixel, 3 cycles after the request
//   vblank              : vertical blanking indicator
//   wr_valid/ready/row/col/data : pixel-write handshake into the FIFO
//   wr_err              : one-cycle pulse when an out-of-range write is dropped
//   bram_en/we/addr/wdata : registered BRAM controls
//   bram_rdata          : BRAM read data (one-cycle latency)
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int ROW_W         = vga_fb_pkg::ROW_W,
   parameter int COL_W         = vga_fb_pkg::COL_W,
   parameter int DATA_W        = vga_fb_pkg::DATA_W,
   parameter int ROWS          = vga_fb_pkg::ROWS,
   parameter int FIFO_DEPTH    = 4,
   parameter bit WR_ONLY_BLANK = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   disp_req,
   input  logic [ROW_W-1:0]       disp_row,
   input  logic [COL_W-1:0]       disp_col,
   output logic [DATA_W-1:0]      disp_data,
   output logic                   disp_valid,
   input  logic                   vblank,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [ROW_W-1:0]       wr_row,
   input  logic [COL_W-1:0]       wr_col,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   wr_err,
   output logic                   bram_en,
   output logic                   bram_we,
   output logic [ROW_W+COL_W-1:0] bram_addr,
   output logic [DATA_W-1:0]      bram_wdata,
   input  logic [DATA_W-1:0]      bram_rdata
);

   import vga_fb_pkg::*;

   localparam int               ADDR_W    = ROW_W + COL_W;
   localparam int               ENTRY_W   = ADDR_W + DATA_W;
   localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS);

   fb_state_t           state_reg, state_next;
   logic                bram_en_reg, bram_en_next;
   logic                bram_we_reg, bram_we_next;
   logic [ADDR_W-1:0]   bram_addr_reg, bram_addr_next;
   logic [DATA_W-1:0]   bram_wdata_reg, bram_wdata_next;

   // Read pipeline: stage 2 marks the cycle bram_rdata is valid.
   logic                rd_stage2_reg;
   logic                rd_stage2_hit_reg;
   logic [DATA_W-1:0]   disp_data_reg;
   logic                disp_valid_reg;
   logic                wr_err_reg;

   logic                wr_accept;
   logic                wr_in_range;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  fifo_head;
   logic                write_eligible;

   // ---------------------------------------------------------------- write side
   // Out-of-range writes still complete the handshake; they are simply
   // never stored, and flagged one cycle later.
   assign wr_ready    = !fifo_full && !reset;
   assign wr_accept   = wr_valid && wr_ready;
   assign wr_in_range = (wr_row < ROW_LIMIT);
   assign fifo_push   = wr_accept && wr_in_range;

   vga_fb_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({fb_addr(wr_row, wr_col), wr_data}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign write_eligible = !fifo_empty && (!WR_ONLY_BLANK || vblank);

   // ------------------------------------------------------------ decision FSM
   always_comb begin
      state_next      = IDLE;
      bram_en_next    = 1'b0;
      bram_we_next    = 1'b0;
      bram_addr_next  = bram_addr_reg;
      bram_wdata_next = bram_wdata_reg;
      fifo_pop        = 1'b0;

      if (disp_req) begin
         // Display always wins; a competing write stays at the FIFO head.
         // Out-of-range rows keep the READ slot (fixed latency) but leave
         // the BRAM disabled so the returned pixel is forced to zero.
         state_next     = READ;
         bram_en_next   = (disp_row < ROW_LIMIT);
         bram_addr_next = fb_addr(disp_row, disp_col);
      end else if (write_eligible) begin
         state_next      = WRITE;
         bram_en_next    = 1'b1;
         bram_we_next    = 1'b1;
         bram_addr_next  = fifo_head[ENTRY_W-1:DATA_W];
         bram_wdata_next = fifo_head[DATA_W-1:0];
         fifo_pop        = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         bram_en_reg       <= 1'b0;
         bram_we_reg       <= 1'b0;
         bram_addr_reg     <= '0;
         bram_wdata_reg    <= '0;
         rd_stage2_reg     <= 1'b0;
         rd_stage2_hit_reg <= 1'b0;
         disp_data_reg     <= '0;
         disp_valid_reg    <= 1'b0;
         wr_err_reg        <= 1'b0;
      end else begin
         state_reg         <= state_next;
         bram_en_reg       <= bram_en_next;
         bram_we_reg       <= bram_we_next;
         bram_addr_reg     <= bram_addr_next;
         bram_wdata_reg    <= bram_wdata_next;
         rd_stage2_reg     <= (state_reg == READ);
         rd_stage2_hit_reg <= (state_reg == READ) && bram_en_reg;
         disp_valid_reg    <= rd_stage2_reg;
         if (rd_stage2_reg) begin
            disp_data_reg <= rd_stage2_hit_reg ? bram_rdata : '0;
         end
         wr_err_reg        <= wr_accept && !wr_in_range;
      end
   end

   assign bram_en    = bram_en_reg;
   assign bram_we    = bram_we_reg;
   assign bram_addr  = bram_addr_reg;
   assign bram_wdata = bram_wdata_reg;
   assign disp_data  = disp_data_reg;
   assign disp_valid = disp_valid_reg;
   assign wr_err     = wr_err_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter with a behavioural single-port BRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        disp_req = 1'b0;
   logic [6:0]  disp_row = '0;
   logic [6:0]  disp_col = '0;
   logic [11:0] disp_data;
   logic        disp_valid;
   logic        vblank = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [6:0]  wr_row = '0;
   logic [6:0]  wr_col = '0;
   logic [11:0] wr_data = '0;
   logic        wr_err;
   logic        bram_en;
   logic        bram_we;
   logic [13:0] bram_addr;
   logic [11:0] bram_wdata;
   logic [11:0] bram_rdata;

   int assert_count = 0;
   int fail_count   = 0;
   int we_count     = 0;
   int valid_count  = 0;

   // Burst-test vectors: rows, columns, data and hand-computed {row,col}.
   logic [6:0]  burst_row  [4] = '{7'd10, 7'd10, 7'd11, 7'd12};
   logic [6:0]  burst_col  [4] = '{7'd1, 7'd2, 7'd3, 7'd4};
   logic [11:0] burst_data [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
   logic [13:0] burst_addr [4] = '{14'h0501, 14'h0502, 14'h0583, 14'h0604};

   always #5 clk = ~clk;

   vga_fb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .disp_req   (disp_req),
      .disp_row   (disp_row),
      .disp_col   (disp_col),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .vblank     (vblank),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_data    (wr_data),
      .wr_err     (wr_err),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata)
   );

   // Behavioural frame-buffer BRAM with a back-door preload port.
   logic [11:0] fb_mem [0:16383];
   logic        preload_en = 1'b0;
   logic [13:0] preload_addr = '0;
   logic [11:0] preload_data = '0;

   always @(posedge clk) begin
      if (preload_en) begin
         fb_mem[preload_addr] <= preload_data;
      end else if (bram_en) begin
         if (bram_we) fb_mem[bram_addr] <= bram_wdata;
         else         bram_rdata <= fb_mem[bram_addr];
      end
   end

   always @(posedge clk) begin
      if (bram_en && bram_we) we_count <= we_count + 1;
      if (disp_valid)         valid_count <= valid_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, actual, expected);
      end else begin
         $display("ok   %s = 0x%0h", tag, actual);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] row, input logic [6:0] col, input logic [11:0] data);
      wr_valid = 1'b1;
      wr_row   = row;
      wr_col   = col;
      wr_data  = data;
      tick;
      wr_valid = 1'b0;
   endtask

   // One-cycle display request; checks address at N+1 and pixel at N+3.
   task automatic do_read(input string tag, input logic [6:0] row, input logic [6:0] col,
                          input logic exp_en, input logic [11:0] exp_data);
      disp_req = 1'b1;
      disp_row = row;
      disp_col = col;
      tick;
      disp_req = 1'b0;
      check({tag, "_en"}, bram_en, exp_en);
      check({tag, "_addr"}, bram_addr, {row, col});
      tick;
      check({tag, "_valid_early"}, disp_valid, 0);
      tick;
      check({tag, "_valid"}, disp_valid, 1);
      check({tag, "_data"}, disp_data, exp_data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, required normal completion");
      $fatal(1, "simulation timeout");
   end

   initial begin
      int base;
      int vbase;

      // ------------------------------------------------------------ reset
      preload_en   = 1'b1;
      preload_addr = 14'h028A;
      preload_data = 12'hA5C;
      tick;
      preload_en = 1'b0;
      tick;
      check("rst_wr_ready", wr_ready, 0);
      check("rst_bram_en", bram_en, 0);
      check("rst_bram_we", bram_we, 0);
      check("rst_bram_addr", bram_addr, 0);
      check("rst_bram_wdata", bram_wdata, 0);
      check("rst_disp_valid", disp_valid, 0);
      check("rst_disp_data", disp_data, 0);
      check("rst_wr_err", wr_err, 0);
      reset = 1'b0;
      #1;
      check("rel_wr_ready", wr_ready, 1);
      tick;

      // ------------------------------------------- basic display read
      do_read("rd_a5c", 7'd5, 7'd10, 1'b1, 12'hA5C);
      check("rd_a5c_addr_hex", {18'd0, 14'h028A}, {18'd0, {7'd5, 7'd10}} & 32'h3FFF);

      // ------------------------------- write held off until vblank
      base = we_count;
      push(7'd3, 7'd7, 12'hFFF);
      repeat (5) tick;
      check("blank_hold_count", we_count - base, 0);
      check("blank_hold_we", bram_we, 0);
      vblank = 1'b1;
      tick;
      vblank = 1'b0;
      check("blank_wr_we", bram_we, 1);
      check("blank_wr_addr", bram_addr, 14'h0187);
      check("blank_wr_data", bram_wdata, 12'hFFF);
      tick;
      check("blank_wr_done", bram_we, 0);
      check("blank_wr_count", we_count - base, 1);
      do_read("rb_fff", 7'd3, 7'd7, 1'b1, 12'hFFF);

      // ------------------------------------ out-of-range display read
      do_read("oor_rd", 7'd100, 7'd0, 1'b0, 12'h000);

      // -------------------------------------- out-of-range write
      vblank = 1'b1;
      base   = we_count;
      wr_valid = 1'b1;
      wr_row   = 7'd96;
      wr_col   = 7'd5;
      wr_data  = 12'hABC;
      #1;
      check("oor_wr_ready", wr_ready, 1);
      tick;
      wr_valid = 1'b0;
      check("oor_wr_err", wr_err, 1);
      tick;
      check("oor_wr_err_clr", wr_err, 0);
      repeat (3) tick;
      check("oor_wr_count", we_count - base, 0);

      // --------------- display priority, fill FIFO, then drain in order
      base     = we_count;
      disp_req = 1'b1;
      disp_row = 7'd0;
      disp_col = 7'd0;
      tick;
      for (int i = 0; i < 4; i++) begin
         push(burst_row[i], burst_col[i], burst_data[i]);
      end
      check("full_wr_ready", wr_ready, 0);
      tick;
      check("full_hold_count", we_count - base, 0);
      disp_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("drain%0d_we", i), bram_we, 1);
         check($sformatf("drain%0d_addr", i), bram_addr, burst_addr[i]);
         check($sformatf("drain%0d_data", i), bram_wdata, burst_data[i]);
      end
      tick;
      check("drain_done_we", bram_we, 0);
      check("drain_wr_ready", wr_ready, 1);
      vblank = 1'b0;
      do_read("rb_333", 7'd11, 7'd3, 1'b1, 12'h333);

      // ------------------------------------------ reset mid-operation
      push(7'd20, 7'd0, 12'h001);
      push(7'd20, 7'd1, 12'h002);
      push(7'd20, 7'd2, 12'h003);
      disp_req = 1'b1;
      disp_row = 7'd5;
      disp_col = 7'd10;
      tick;
      disp_req = 1'b0;
      base  = we_count;
      vbase = valid_count;
      reset = 1'b1;
      #1;
      check("mid_rst_bram_en", bram_en, 0);
      check("mid_rst_wr_ready", wr_ready, 0);
      tick;
      tick;
      vblank = 1'b1;
      reset  = 1'b0;
      tick;
      check("mid_rel_wr_ready", wr_ready, 1);
      repeat (6) tick;
      check("mid_rst_valids", valid_count - vbase, 0);
      check("mid_rst_writes", we_count - base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
